// File: rtl/alu_reg_bank_if.sv
// Operand/result bus bundle between the execute-stage control and alu_reg_bank.
// Control drives through the master modport; the register bank drives results through the slave modport.
interface alu_reg_bank_if #(
  parameter int W     = 16,
  parameter int NX    = 2,
  parameter int NY    = 2,
  parameter int NBANK = 2,
  parameter int BW    = 1
);
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;

  logic          GO_C;
  logic [BW-1:0] BANK;
  logic [W-1:0]  WDATA;
  logic          WE;
  logic [3:0]    WSEL;
  logic [XW-1:0] XSEL;
  logic [YW-1:0] YSEL;
  logic          SELAY;
  logic          ZERO_X, ZERO_Y, INV_X, INV_Y;
  logic [W-1:0]  ALU;
  logic          AV, AC, SAT_EN;
  logic          UPD_AR, UPD_AF;
  logic          DIV_START, QIN;
  logic [3:0]    RDSEL;
  logic [W-1:0]  X, Y;
  logic          X_MSB, Y_MSB;
  logic [W-1:0]  RDATA, AR_OUT;
  logic          DIV_BUSY, DIV_DONE, SATF;

  modport master (
    output GO_C, BANK, WDATA, WE, WSEL, XSEL, YSEL, SELAY,
           ZERO_X, ZERO_Y, INV_X, INV_Y, ALU, AV, AC, SAT_EN,
           UPD_AR, UPD_AF, DIV_START, QIN, RDSEL,
    input  X, Y, X_MSB, Y_MSB, RDATA, AR_OUT, DIV_BUSY, DIV_DONE, SATF
  );

  modport slave (
    input  GO_C, BANK, WDATA, WE, WSEL, XSEL, YSEL, SELAY,
           ZERO_X, ZERO_Y, INV_X, INV_Y, ALU, AV, AC, SAT_EN,
           UPD_AR, UPD_AF, DIV_START, QIN, RDSEL,
    output X, Y, X_MSB, Y_MSB, RDATA, AR_OUT, DIV_BUSY, DIV_DONE, SATF
  );
endinterface

// File: rtl/alu_reg_bank.sv
// Banked AX/AY/AF/AR file with saturating AR capture and a W-step divide sequencer.
// Reads are combinational (writes visible next cycle); GO_C=0 freezes all state except reset.
module alu_reg_bank #(
  parameter int W     = 16,
  parameter int NX    = 2,
  parameter int NY    = 2,
  parameter int NBANK = 2,
  parameter int BW    = 1
) (
  input logic          DSPCLK,
  input logic          RST,
  alu_reg_bank_if.slave b
);
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int CW = $clog2(W);
  localparam logic [3:0]   NX_END  = 4'(NX);
  localparam logic [3:0]   AY_END  = 4'(8 + NY);
  localparam logic [CW-1:0] LAST   = CW'(W - 1);
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [W-1:0]  ax_q [NBANK][NX];
  logic [W-1:0]  ax_d [NBANK][NX];
  logic [W-1:0]  ay_q [NBANK][NY];
  logic [W-1:0]  ay_d [NBANK][NY];
  logic [W-1:0]  af_q [NBANK];
  logic [W-1:0]  af_d [NBANK];
  logic [W-1:0]  ar_q [NBANK];
  logic [W-1:0]  ar_d [NBANK];
  logic          satf_q, satf_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] db_q, db_d;

  logic [3:0]    wsel_y, rdsel_y;
  logic          wsel_is_ay, guard;
  logic [W-1:0]  x_raw, y_raw, rd;

  assign wsel_y     = b.WSEL - 4'd8;
  assign rdsel_y    = b.RDSEL - 4'd8;
  assign wsel_is_ay = (b.WSEL >= 4'd8) && (b.WSEL < AY_END);
  // The running sequence owns AY0/AF of its latched bank until it finishes.
  assign guard      = (state_q == S_RUN) && (b.BANK == db_q);

  always_comb begin
    ax_d    = ax_q;
    ay_d    = ay_q;
    af_d    = af_q;
    ar_d    = ar_q;
    satf_d  = satf_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    if (b.GO_C) begin
      if (b.WE && (b.WSEL < NX_END))
        ax_d[b.BANK][b.WSEL[XW-1:0]] = b.WDATA;
      if (b.WE && wsel_is_ay && !(guard && (wsel_y == 4'd0)))
        ay_d[b.BANK][wsel_y[YW-1:0]] = b.WDATA;
      if (b.WE && (b.WSEL == 4'd14)) begin
        ar_d[b.BANK] = b.WDATA;
        satf_d       = 1'b0;
      end else if (b.UPD_AR) begin
        if (b.AV && b.SAT_EN) begin
          ar_d[b.BANK] = b.AC ? SAT_NEG : SAT_POS;
          satf_d       = 1'b1;
        end else begin
          ar_d[b.BANK] = b.ALU;
        end
      end
      if (!guard) begin
        if (b.WE && (b.WSEL == 4'd15))
          af_d[b.BANK] = b.WDATA;
        else if (b.UPD_AF)
          af_d[b.BANK] = b.ALU;
      end
      case (state_q)
        S_IDLE: begin
          if (b.DIV_START) begin
            state_d = S_RUN;
            db_d    = b.BANK;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          ay_d[db_q][0] = {ay_q[db_q][0][W-2:0], b.QIN};
          af_d[db_q]    = {b.ALU[W-2:0], ay_q[db_q][0][W-1]};
          cnt_d         = cnt_q + CW'(1);
          if (cnt_q == LAST)
            state_d = S_DONE;
        end
        default: ;
      endcase
    end
    // DONE is a fixed one-cycle pulse, independent of GO_C.
    if (state_q == S_DONE)
      state_d = S_IDLE;
  end

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      ax_q    <= '{default: '0};
      ay_q    <= '{default: '0};
      af_q    <= '{default: '0};
      ar_q    <= '{default: '0};
      satf_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      db_q    <= '0;
    end else begin
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      af_q    <= af_d;
      ar_q    <= ar_d;
      satf_q  <= satf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  always_comb begin
    x_raw = ax_q[b.BANK][b.XSEL];
    y_raw = b.SELAY ? ay_q[b.BANK][b.YSEL] : af_q[b.BANK];
    rd    = '0;
    if (b.RDSEL < NX_END)
      rd = ax_q[b.BANK][b.RDSEL[XW-1:0]];
    else if ((b.RDSEL >= 4'd8) && (b.RDSEL < AY_END))
      rd = ay_q[b.BANK][rdsel_y[YW-1:0]];
    else if (b.RDSEL == 4'd14)
      rd = ar_q[b.BANK];
    else if (b.RDSEL == 4'd15)
      rd = af_q[b.BANK];
  end

  assign b.X        = b.INV_X ? ~(b.ZERO_X ? '0 : x_raw) : (b.ZERO_X ? '0 : x_raw);
  assign b.Y        = b.INV_Y ? ~(b.ZERO_Y ? '0 : y_raw) : (b.ZERO_Y ? '0 : y_raw);
  assign b.X_MSB    = x_raw[W-1];
  assign b.Y_MSB    = y_raw[W-1];
  assign b.RDATA    = rd;
  assign b.AR_OUT   = ar_q[b.BANK];
  assign b.DIV_BUSY = (state_q == S_RUN);
  assign b.DIV_DONE = (state_q == S_DONE);
  assign b.SATF     = satf_q;
endmodule

// File: tb/tb_alu_reg_bank.sv
// Directed bench for alu_reg_bank: vector table for the register/operand paths,
// hand-written sequences for saturation, GO_C stalls, divide runs and mid-run reset.
module tb_alu_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   busy_n, done_n, done_at;

  always #5 clk = ~clk;

  alu_reg_bank_if #(.W(16), .NX(2), .NY(2), .NBANK(2), .BW(1)) bus ();

  alu_reg_bank #(.W(16), .NX(2), .NY(2), .NBANK(2), .BW(1)) dut (
    .DSPCLK (clk),
    .RST    (rst),
    .b      (bus)
  );

  typedef struct packed {
    logic        bank;
    logic        we;
    logic [3:0]  wsel;
    logic [15:0] wdata;
    logic        xsel, ysel, selay, zx, ix, zy, iy;
    logic [3:0]  rdsel;
    logic [15:0] x, y, rd;
    logic        xm, ym;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.GO_C = 1'b1;  bus.BANK = 1'b0; bus.WDATA = '0; bus.WE = 1'b0; bus.WSEL = '0;
    bus.XSEL = '0;    bus.YSEL = '0;   bus.SELAY = 1'b1;
    bus.ZERO_X = 1'b0; bus.ZERO_Y = 1'b0; bus.INV_X = 1'b0; bus.INV_Y = 1'b0;
    bus.ALU = '0; bus.AV = 1'b0; bus.AC = 1'b0; bus.SAT_EN = 1'b0;
    bus.UPD_AR = 1'b0; bus.UPD_AF = 1'b0; bus.DIV_START = 1'b0; bus.QIN = 1'b0;
    bus.RDSEL = '0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [15:0] d);
    bus.WE = 1'b1; bus.WSEL = sel; bus.WDATA = d;
    tick();
    bus.WE = 1'b0;
  endtask

  // Observe DIV_BUSY/DIV_DONE for n cycles with no other stimulus.
  task automatic window(input int n, output int bn, output int dn, output int da);
    bn = 0; dn = 0; da = -1;
    for (int k = 0; k < n; k++) begin
      bus.DIV_START = 1'b0;
      #1;
      if (bus.DIV_BUSY) bn++;
      if (bus.DIV_DONE) begin dn++; da = k; end
      tick();
    end
  endtask

  initial begin
    vt[0] = '{1'b0,1'b1,4'd1, 16'h1234, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd1,  16'h1234,16'h0000,16'h1234, 1'b0,1'b0};
    vt[1] = '{1'b1,1'b1,4'd1, 16'hABCD, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd1,  16'hABCD,16'h0000,16'hABCD, 1'b1,1'b0};
    vt[2] = '{1'b0,1'b0,4'd1, 16'h0000, 1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0, 4'd1,  16'hEDCB,16'h0000,16'h1234, 1'b0,1'b0};
    vt[3] = '{1'b1,1'b1,4'd8, 16'h00F0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd8,  16'h0000,16'h00F0,16'h00F0, 1'b0,1'b0};
    vt[4] = '{1'b1,1'b1,4'd9, 16'h0F0F, 1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1, 4'd9,  16'h0000,16'hF0F0,16'h0F0F, 1'b1,1'b0};
    vt[5] = '{1'b1,1'b1,4'd15,16'h2222, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 4'd15, 16'hFFFF,16'h2222,16'h2222, 1'b1,1'b0};
    vt[6] = '{1'b0,1'b1,4'd5, 16'h9999, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 4'd5,  16'h0000,16'h0000,16'h0000, 1'b0,1'b0};
    vt[7] = '{1'b0,1'b1,4'd14,16'h3333, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1, 4'd14, 16'h1234,16'hFFFF,16'h3333, 1'b0,1'b0};
    vt[8] = '{1'b1,1'b0,4'd0, 16'h0000, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd14, 16'h0000,16'h0F0F,16'h0000, 1'b0,1'b0};
    vt[9] = '{1'b0,1'b1,4'd8, 16'h8001, 1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0, 4'd8,  16'hEDCB,16'h8001,16'h8001, 1'b0,1'b1};

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    bus.RDSEL = 4'd1; bus.XSEL = 1'b1;
    #1;
    check("rst_x", bus.X, 16'h0);
    check("rst_y", bus.Y, 16'h0);
    check("rst_rdata", bus.RDATA, 16'h0);
    check("rst_ar", bus.AR_OUT, 16'h0);
    check("rst_busy", bus.DIV_BUSY, 1'b0);
    check("rst_done", bus.DIV_DONE, 1'b0);
    check("rst_satf", bus.SATF, 1'b0);

    for (int i = 0; i < 10; i++) begin
      bus.BANK = vt[i].bank; bus.WE = vt[i].we; bus.WSEL = vt[i].wsel; bus.WDATA = vt[i].wdata;
      bus.XSEL = vt[i].xsel; bus.YSEL = vt[i].ysel; bus.SELAY = vt[i].selay;
      bus.ZERO_X = vt[i].zx; bus.INV_X = vt[i].ix; bus.ZERO_Y = vt[i].zy; bus.INV_Y = vt[i].iy;
      bus.RDSEL = vt[i].rdsel;
      tick();
      check($sformatf("vec%0d_x", i), bus.X, vt[i].x);
      check($sformatf("vec%0d_y", i), bus.Y, vt[i].y);
      check($sformatf("vec%0d_rdata", i), bus.RDATA, vt[i].rd);
      check($sformatf("vec%0d_xmsb", i), bus.X_MSB, vt[i].xm);
      check($sformatf("vec%0d_ymsb", i), bus.Y_MSB, vt[i].ym);
    end

    // AR saturation, stickiness and bus-write clear; AF capture priority
    idle();
    bus.UPD_AR = 1'b1; bus.ALU = 16'h0100; bus.AV = 1'b1; bus.AC = 1'b1; bus.SAT_EN = 1'b1;
    tick();
    check("sat_neg_ar", bus.AR_OUT, 16'h8000);
    check("sat_neg_satf", bus.SATF, 1'b1);
    bus.AC = 1'b0;
    tick();
    check("sat_pos_ar", bus.AR_OUT, 16'h7FFF);
    bus.AV = 1'b0; bus.ALU = 16'h0042;
    tick();
    check("nosat_ar", bus.AR_OUT, 16'h0042);
    check("satf_sticky", bus.SATF, 1'b1);
    bus.AV = 1'b1; bus.SAT_EN = 1'b0; bus.ALU = 16'h0100;
    tick();
    check("sat_dis_ar", bus.AR_OUT, 16'h0100);
    bus.SAT_EN = 1'b1; bus.WE = 1'b1; bus.WSEL = 4'd14; bus.WDATA = 16'h0005;
    tick();
    check("ar_bus_prio", bus.AR_OUT, 16'h0005);
    check("satf_clear", bus.SATF, 1'b0);
    idle();
    bus.UPD_AF = 1'b1; bus.ALU = 16'h7777; bus.RDSEL = 4'd15;
    tick();
    check("af_upd", bus.RDATA, 16'h7777);
    bus.WE = 1'b1; bus.WSEL = 4'd15; bus.WDATA = 16'h1111;
    tick();
    check("af_bus_prio", bus.RDATA, 16'h1111);
    idle();
    bus.GO_C = 1'b0; bus.UPD_AR = 1'b1; bus.ALU = 16'h0ABC;
    tick();
    check("ar_hold_goc0", bus.AR_OUT, 16'h0005);

    // GO_C gating and same-cycle old value on writes
    idle();
    bus.GO_C = 1'b0; bus.WE = 1'b1; bus.WSEL = 4'd8; bus.WDATA = 16'h5555; bus.RDSEL = 4'd8;
    tick();
    check("ay0_hold_goc0", bus.RDATA, 16'h8001);
    bus.GO_C = 1'b1;
    #1;
    check("ay0_old_same_cycle", bus.RDATA, 16'h8001);
    tick();
    check("ay0_written", bus.RDATA, 16'h5555);

    // Divide run with QIN=1, DIV_START retriggers in RUN and DONE
    idle();
    wr(4'd8, 16'h8000); wr(4'd15, 16'h0000);
    bus.ALU = 16'h0000; bus.QIN = 1'b1; bus.DIV_START = 1'b1;
    tick();
    bus.RDSEL = 4'd15;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < 20; k++) begin
      bus.DIV_START = (k == 5) || (k == 16);
      #1;
      if (bus.DIV_BUSY) busy_n++;
      if (bus.DIV_DONE) begin done_n++; done_at = k; end
      if (k == 1) check("div_af_step1", bus.RDATA, 16'h0001);
      tick();
    end
    check("div1_busy_cycles", busy_n, 16);
    check("div1_done_count", done_n, 1);
    check("div1_done_at", done_at, 16);
    bus.RDSEL = 4'd8;
    #1;
    check("div1_ay0", bus.RDATA, 16'hFFFF);

    // Divide with 3-cycle stall, ignored AY0 write, other write, bank toggle
    idle();
    bus.BANK = 1'b1; wr(4'd8, 16'h1357); wr(4'd15, 16'h2468);
    bus.BANK = 1'b0; wr(4'd8, 16'h8000); wr(4'd15, 16'h0000);
    bus.ALU = 16'h0003; bus.QIN = 1'b1; bus.DIV_START = 1'b1;
    tick();
    bus.DIV_START = 1'b0; bus.RDSEL = 4'd8; bus.XSEL = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < 24; k++) begin
      bus.GO_C  = !((k >= 4) && (k <= 6));
      bus.WE    = (k == 2) || (k == 3);
      bus.WSEL  = (k == 2) ? 4'd8 : 4'd0;
      bus.WDATA = (k == 2) ? 16'h0000 : 16'h4444;
      bus.BANK  = (k == 8) || (k == 9);
      #1;
      if (bus.DIV_BUSY) busy_n++;
      if (bus.DIV_DONE) begin done_n++; done_at = k; end
      if (k == 3) check("div2_ay0_write_ignored", bus.RDATA, 16'h0007);
      if (k == 4) check("div2_other_write", bus.X, 16'h4444);
      if (k == 8) check("div2_bank1_ay0_mid", bus.RDATA, 16'h1357);
      tick();
    end
    check("div2_busy_cycles", busy_n, 19);
    check("div2_done_count", done_n, 1);
    check("div2_done_at", done_at, 19);
    idle();
    bus.RDSEL = 4'd8;
    #1;
    check("div2_ay0_b0", bus.RDATA, 16'hFFFF);
    bus.RDSEL = 4'd15;
    #1;
    check("div2_af_b0", bus.RDATA, 16'h0006);
    bus.BANK = 1'b1; bus.RDSEL = 4'd8;
    #1;
    check("div2_ay0_b1", bus.RDATA, 16'h1357);
    bus.RDSEL = 4'd15;
    #1;
    check("div2_af_b1", bus.RDATA, 16'h2468);

    // Reset at step 7 with GO_C low, then a clean restart
    idle();
    wr(4'd8, 16'h8000);
    bus.UPD_AR = 1'b1; bus.ALU = 16'h0001; bus.AV = 1'b1; bus.AC = 1'b1; bus.SAT_EN = 1'b1;
    tick();
    bus.UPD_AR = 1'b0; bus.AV = 1'b0; bus.AC = 1'b0; bus.SAT_EN = 1'b0;
    check("pre_rst_satf", bus.SATF, 1'b1);
    bus.QIN = 1'b1; bus.DIV_START = 1'b1;
    tick();
    bus.DIV_START = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("pre_rst_busy", bus.DIV_BUSY, 1'b1);
    rst = 1'b1; bus.GO_C = 1'b0;
    tick();
    rst = 1'b0; bus.GO_C = 1'b1;
    bus.XSEL = 1'b1; bus.SELAY = 1'b0; bus.RDSEL = 4'd8;
    #1;
    check("mid_rst_busy", bus.DIV_BUSY, 1'b0);
    check("mid_rst_done", bus.DIV_DONE, 1'b0);
    check("mid_rst_satf", bus.SATF, 1'b0);
    check("mid_rst_ar", bus.AR_OUT, 16'h0);
    check("mid_rst_ay0", bus.RDATA, 16'h0);
    check("mid_rst_x", bus.X, 16'h0);
    check("mid_rst_y", bus.Y, 16'h0);
    window(20, busy_n, done_n, done_at);
    check("post_rst_busy_cycles", busy_n, 0);
    check("post_rst_done_count", done_n, 0);
    bus.DIV_START = 1'b1;
    tick();
    window(20, busy_n, done_n, done_at);
    check("restart_busy_cycles", busy_n, 16);
    check("restart_done_at", done_at, 16);
    bus.RDSEL = 4'd8;
    #1;
    check("restart_ay0", bus.RDATA, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_reg_bank.md
Name: alu_reg_bank

Overview:
Parametrised ALU operand/result register bank, next generation of the execute-stage AX/AY/AF/AR file. It generalises width, X/Y register count and bank count (beyond the single shadow set), and adds an autonomous multi-cycle divide-step sequencer and a sticky saturation flag. It sits between the DMD/PMD buses and the ALU datapath, supplying X/Y operands and capturing AF/AR results.

Parameters:
W, 16, data width of every register and bus
NX, 2, number of AX registers per bank (AX0..AXn)
NY, 2, number of AY registers per bank (AY0 is divide quotient register)
NBANK, 2, register banks (bank 0 = primary, others = shadow/alternate)
BW, 1, bank select width, clog2(NBANK), min 1

Ports:
DSPCLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
GO_C  in  1  pipeline advance; no state change when 0, except RST
BANK  in  BW  active bank for reads and writes
WDATA  in  W  bus write data (muxed DMD/PMD upstream)
WE  in  1  bus write strobe
WSEL  in  4  target: 0..NX-1 AX, 8..8+NY-1 AY, 14 AR, 15 AF
XSEL  in  clog2(NX)  AX operand select
YSEL  in  clog2(NY)  AY operand select
SELAY  in  1  Y source: 1=AY[YSEL], 0=AF
ZERO_X, ZERO_Y, INV_X, INV_Y  in  1 each  operand forcing/inversion
ALU  in  W  ALU result
AV, AC  in  1  ALU overflow/carry for current result
SAT_EN  in  1  saturate AR on overflow
UPD_AR, UPD_AF  in  1  capture ALU result into AR / AF
DIV_START  in  1  start W-step divide sequence
QIN  in  1  quotient bit from ALU for current step
RDSEL  in  4  readback target (WSEL encoding)
X, Y  out  W  ALU operands
X_MSB, Y_MSB  out  1  sign of operand before ZERO/INV
RDATA  out  W  registered-free readback of RDSEL in active bank
AR_OUT  out  W  AR of active bank
DIV_BUSY  out  1  sequencer running
DIV_DONE  out  1  one-cycle pulse after final step
SATF  out  1  sticky: AR was saturated since last AR bus write

Behaviour:
- RST: all AX/AY/AF/AR of all banks = 0, sequencer IDLE, counter 0, DIV_BUSY=0, DIV_DONE=0, SATF=0. RST overrides GO_C.
- Writes: only when GO_C=1; affect bank BANK only; other banks hold. WSEL codes outside configured range: write ignored, RDATA=0.
- Read paths (X, Y, RDATA, AR_OUT) combinational from current register state; write in cycle n visible from cycle n+1 (old value same cycle).
- X = INV_X ? ~Xt : Xt, Xt = ZERO_X ? 0 : AX[BANK][XSEL]; X_MSB = AX[BANK][XSEL][W-1]. Y identically from SELAY mux.
- AR capture (UPD_AR, GO_C): AV&SAT_EN -> AC ? {1,0..0} (0x8000) : {0,1..1} (0x7FFF), SATF<=1; else ALU. Bus write to AR (WE, WSEL=14) has priority over UPD_AR, loads WDATA, clears SATF.
- AF capture: UPD_AF loads ALU; in divide step loads {ALU[W-2:0], AY0[W-1]}. Bus write to AF has priority over UPD_AF but not over an active divide step.
- Divide FSM: IDLE -> RUN on DIV_START&GO_C; latches bank DB=BANK, counter=0. RUN: each GO_C=1 cycle: AY0[DB] <= {AY0[W-2:0], QIN}, AF[DB] shifted as above, counter++. GO_C=0 stalls (no step). After step with counter=W-1 -> DONE for one cycle (DIV_DONE=1, DIV_BUSY=0) -> IDLE. DIV_BUSY=1 only in RUN.
- DIV_START in RUN/DONE ignored. Bus writes to AY0/AF of DB during RUN ignored (sequencer wins); writes to other registers proceed. BANK changes during RUN do not move the sequence.
- RST mid-divide: immediate IDLE, registers 0, no DIV_DONE.

Test Plan:
- RST then write AX1 bank0=0x1234, BANK=1 write AX1=0xABCD; XSEL=1: BANK=0 -> X=0x1234, BANK=1 -> X=0xABCD; INV_X -> 0xEDCB at bank0.
- UPD_AR with ALU=0x0100, AV=1, AC=1, SAT_EN=1 -> AR_OUT=0x8000, SATF=1; AC=0 -> 0x7FFF; bus write AR=0x0005 -> SATF=0.
- Write with GO_C=0 and WE=1 to AY0=0x5555 -> unchanged; same with GO_C=1 -> RDATA(RDSEL=8)=0x5555 next cycle.
- AY0=0x8000, AF=0, DIV_START, QIN=1 all steps, ALU=0 -> after 16 advancing cycles AY0=0xFFFF, DIV_DONE pulses exactly once cycle 17, DIV_BUSY high 16 cycles.
- Divide with GO_C low 3 cycles mid-run -> DIV_DONE delayed by 3; bus write AY0 during RUN ignored; BANK toggle mid-run leaves bank1 untouched.
- RST asserted at step 7 -> all outputs 0, DIV_DONE never pulses; new DIV_START restarts from counter 0.
